// File: rtl/game_pkg.sv
// game_pkg: shared state type, display-mode codes and winner codes for the
// reaction game round controller.
package game_pkg;

   // Round sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_COUNTDOWN  = 3'd1,
      ST_DELAY      = 3'd2,
      ST_REACT      = 3'd3,
      ST_RESULT     = 3'd4,
      ST_MATCH_OVER = 3'd5
   } state_e;

   // game_mode codes driven to the display block.
   localparam logic [1:0] MODE_COUNTDOWN = 2'b00;
   localparam logic [1:0] MODE_STOPWATCH = 2'b01;
   localparam logic [1:0] MODE_SCORE     = 2'b10;

   // winner codes.
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   // Display mode shown while the sequencer sits in a given state.
   function automatic logic [1:0] mode_of(input state_e s);
      case (s)
         ST_COUNTDOWN:       return MODE_COUNTDOWN;
         ST_DELAY, ST_REACT: return MODE_STOPWATCH;
         default:            return MODE_SCORE;
      endcase
   endfunction

endpackage

// File: rtl/round_sequencer_timer.sv
// react_timeout_timer: counts 1 kHz ticks during the reaction window and
// flags the tick on which the count reaches TIMEOUT_MS.
module react_timeout_timer #(
   parameter int unsigned TIMEOUT_MS = 2000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic tick_i,
   output logic expired_o
);

   localparam int unsigned    CW    = $clog2(TIMEOUT_MS + 1);
   localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_MS);
   localparam logic [CW-1:0]  ONE   = CW'(1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear holds the count at zero; otherwise advance on tick, saturating at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + ONE;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Terminal flag compares the incremented value, so it fires on the limit tick itself.
   assign expired_o = !clr_i && tick_i && ((cnt_q + ONE) == LIMIT);

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: match-level controller for the two-player reaction game.
// Sequences countdown / random delay / stopwatch, arbitrates player hits,
// detects jump starts and timeouts, and keeps the round-win tally.
//
// Handshake note: there is no valid/ready flow here. Every input is sampled
// through one register stage (hits and start as rising edges, the rest as
// levels), and the FSM acts on those registered samples, so an input seen at
// clock edge N changes state and outputs at edge N+1. All outputs are registers.
module round_sequencer
   import game_pkg::*;
#(
   parameter int unsigned WINS_TO_MATCH = 3,
   parameter int unsigned TIMEOUT_MS    = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       tick_1khz,
   input  logic       countdown_done,
   input  logic       delay_done,
   input  logic       p1_hit,
   input  logic       p2_hit,
   output logic       countdown_start,
   output logic       delay_start,
   output logic       stopwatch_clear,
   output logic       stopwatch_run,
   output logic [1:0] game_mode,
   output logic [1:0] winner,
   output logic       jump_start,
   output logic [3:0] p1_wins,
   output logic [3:0] p2_wins,
   output logic       match_over,
   output logic [2:0] dbg_state
);

   localparam logic [3:0] WINS_C = 4'(WINS_TO_MATCH);

   // Input sampling / edge detection.
   logic start_prev_q, p1_prev_q, p2_prev_q;
   logic start_edge_q, p1_edge_q, p2_edge_q;
   logic tick_q, cd_done_q, dl_done_q;

   // FSM and output registers.
   state_e     state_q, state_d;
   logic       countdown_start_q, countdown_start_d;
   logic       delay_start_q, delay_start_d;
   logic       stopwatch_clear_q, stopwatch_clear_d;
   logic       stopwatch_run_q, stopwatch_run_d;
   logic [1:0] game_mode_q, game_mode_d;
   logic [1:0] winner_q, winner_d;
   logic       jump_start_q, jump_start_d;
   logic [3:0] p1_wins_q, p1_wins_d;
   logic [3:0] p2_wins_q, p2_wins_d;
   logic       match_over_q, match_over_d;

   // Combinational helpers.
   logic       any_hit;
   logic [1:0] react_code;
   logic [1:0] jump_code;
   logic       round_end;
   logic [1:0] round_winner;
   logic [3:0] p1_inc, p2_inc;
   logic       timed_out;

   // Register inputs and detect rising edges; previous values reset high so
   // inputs already held at reset never produce an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_prev_q <= 1'b1;
         p1_prev_q    <= 1'b1;
         p2_prev_q    <= 1'b1;
         start_edge_q <= 1'b0;
         p1_edge_q    <= 1'b0;
         p2_edge_q    <= 1'b0;
         tick_q       <= 1'b0;
         cd_done_q    <= 1'b0;
         dl_done_q    <= 1'b0;
      end else begin
         start_prev_q <= start;
         p1_prev_q    <= p1_hit;
         p2_prev_q    <= p2_hit;
         start_edge_q <= start & ~start_prev_q;
         p1_edge_q    <= p1_hit & ~p1_prev_q;
         p2_edge_q    <= p2_hit & ~p2_prev_q;
         tick_q       <= tick_1khz;
         cd_done_q    <= countdown_done;
         dl_done_q    <= delay_done;
      end
   end

   // Reaction window timer; held clear whenever we are not in REACT so it
   // starts from zero on every entry.
   react_timeout_timer #(
      .TIMEOUT_MS (TIMEOUT_MS)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q != ST_REACT),
      .tick_i    (tick_q),
      .expired_o (timed_out)
   );

   // Next state, scoring and next output values for the round FSM.
   always_comb begin
      state_d           = state_q;
      countdown_start_d = 1'b0;
      delay_start_d     = 1'b0;
      stopwatch_clear_d = 1'b0;
      winner_d          = winner_q;
      jump_start_d      = jump_start_q;
      p1_wins_d         = p1_wins_q;
      p2_wins_d         = p2_wins_q;
      match_over_d      = match_over_q;
      round_end         = 1'b0;
      round_winner      = WIN_NONE;
      p1_inc            = p1_wins_q + 4'd1;
      p2_inc            = p2_wins_q + 4'd1;
      any_hit           = p1_edge_q | p2_edge_q;
      // Winner codes line up with {p2,p1}: a legal hit names the hitter,
      // a jump start names the other player; both at once is a tie either way.
      react_code        = {p2_edge_q, p1_edge_q};
      jump_code         = {p1_edge_q, p2_edge_q};

      case (state_q)
         ST_IDLE, ST_RESULT, ST_MATCH_OVER: begin
            if (start_edge_q) begin
               state_d           = ST_COUNTDOWN;
               countdown_start_d = 1'b1;
               stopwatch_clear_d = 1'b1;
               winner_d          = WIN_NONE;
               jump_start_d      = 1'b0;
               if (state_q == ST_MATCH_OVER) begin
                  p1_wins_d    = 4'd0;
                  p2_wins_d    = 4'd0;
                  match_over_d = 1'b0;
               end
            end
         end
         ST_COUNTDOWN: begin
            if (any_hit) begin
               round_end    = 1'b1;
               jump_start_d = 1'b1;
               round_winner = jump_code;
            end else if (cd_done_q) begin
               state_d       = ST_DELAY;
               delay_start_d = 1'b1;
            end
         end
         ST_DELAY: begin
            if (any_hit) begin
               round_end    = 1'b1;
               jump_start_d = 1'b1;
               round_winner = jump_code;
            end else if (dl_done_q) begin
               state_d = ST_REACT;
            end
         end
         ST_REACT: begin
            // A hit on the same tick as the timeout takes precedence.
            if (any_hit) begin
               round_end    = 1'b1;
               round_winner = react_code;
            end else if (timed_out) begin
               round_end    = 1'b1;
               round_winner = WIN_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (round_end) begin
         state_d  = ST_RESULT;
         winner_d = round_winner;
         if (round_winner == WIN_P1) begin
            p1_wins_d = p1_inc;
            if (p1_inc == WINS_C) begin
               state_d      = ST_MATCH_OVER;
               match_over_d = 1'b1;
            end
         end else if (round_winner == WIN_P2) begin
            p2_wins_d = p2_inc;
            if (p2_inc == WINS_C) begin
               state_d      = ST_MATCH_OVER;
               match_over_d = 1'b1;
            end
         end
      end

      stopwatch_run_d = (state_d == ST_REACT);
      game_mode_d     = mode_of(state_d);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_IDLE;
         countdown_start_q <= 1'b0;
         delay_start_q     <= 1'b0;
         stopwatch_clear_q <= 1'b0;
         stopwatch_run_q   <= 1'b0;
         game_mode_q       <= MODE_SCORE;
         winner_q          <= WIN_NONE;
         jump_start_q      <= 1'b0;
         p1_wins_q         <= 4'd0;
         p2_wins_q         <= 4'd0;
         match_over_q      <= 1'b0;
      end else begin
         state_q           <= state_d;
         countdown_start_q <= countdown_start_d;
         delay_start_q     <= delay_start_d;
         stopwatch_clear_q <= stopwatch_clear_d;
         stopwatch_run_q   <= stopwatch_run_d;
         game_mode_q       <= game_mode_d;
         winner_q          <= winner_d;
         jump_start_q      <= jump_start_d;
         p1_wins_q         <= p1_wins_d;
         p2_wins_q         <= p2_wins_d;
         match_over_q      <= match_over_d;
      end
   end

   assign countdown_start = countdown_start_q;
   assign delay_start     = delay_start_q;
   assign stopwatch_clear = stopwatch_clear_q;
   assign stopwatch_run   = stopwatch_run_q;
   assign game_mode       = game_mode_q;
   assign winner          = winner_q;
   assign jump_start      = jump_start_q;
   assign p1_wins         = p1_wins_q;
   assign p2_wins         = p2_wins_q;
   assign match_over      = match_over_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: drives whole rounds of the reaction game and checks each
// round outcome against a score-keeping model of the game rules.
`timescale 1ns/1ps
module tb_round_sequencer;
   import game_pkg::*;

   localparam int WINS = 3;
   localparam int TMO  = 2000;
   localparam int RW   = 12;

   localparam int K_REACT     = 0;
   localparam int K_JUMP_CD   = 1;
   localparam int K_JUMP_DL   = 2;
   localparam int K_TIMEOUT   = 3;
   localparam int K_LAST_TICK = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, tick_1khz = 1'b0, countdown_done = 1'b0, delay_done = 1'b0;
   logic p1_hit = 1'b0, p2_hit = 1'b0;
   logic countdown_start, delay_start, stopwatch_clear, stopwatch_run;
   logic jump_start, match_over;
   logic [1:0] game_mode, winner;
   logic [3:0] p1_wins, p2_wins;
   logic [2:0] dbg_state;

   round_sequencer #(
      .WINS_TO_MATCH (WINS),
      .TIMEOUT_MS    (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .tick_1khz       (tick_1khz),
      .countdown_done  (countdown_done),
      .delay_done      (delay_done),
      .p1_hit          (p1_hit),
      .p2_hit          (p2_hit),
      .countdown_start (countdown_start),
      .delay_start     (delay_start),
      .stopwatch_clear (stopwatch_clear),
      .stopwatch_run   (stopwatch_run),
      .game_mode       (game_mode),
      .winner          (winner),
      .jump_start      (jump_start),
      .p1_wins         (p1_wins),
      .p2_wins         (p2_wins),
      .match_over      (match_over),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Scoreboard: expected {winner, jump_start, p1_wins, p2_wins, match_over} per round.
   logic [RW-1:0] exp_q[$];

   // Reference model of the match score.
   int m_p1 = 0;
   int m_p2 = 0;
   bit m_mo = 1'b0;

   bit         mon_en    = 1'b0;
   bit         hold_p1   = 1'b0;
   logic [1:0] prev_mode = 2'b10;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: outcome of one round from the game rules.
   task automatic predict(input int kind, input logic [1:0] hits, output logic [RW-1:0] e);
      logic [1:0] w;
      logic       j;
      j = (kind == K_JUMP_CD) || (kind == K_JUMP_DL);
      if (kind == K_TIMEOUT)   w = WIN_NONE;
      else if (hits == 2'b11)  w = WIN_TIE;
      else if (j)              w = (hits == 2'b01) ? WIN_P2 : WIN_P1;
      else                     w = (hits == 2'b01) ? WIN_P1 : WIN_P2;
      if (w == WIN_P1) m_p1++;
      else if (w == WIN_P2) m_p2++;
      if (m_p1 == WINS || m_p2 == WINS) m_mo = 1'b1;
      e = {w, j, 4'(m_p1), 4'(m_p2), m_mo};
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_hits(input logic [1:0] h);
      p1_hit = h[0] | hold_p1;
      p2_hit = h[1];
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return countdown_start;
         1:       return delay_start;
         2:       return stopwatch_run;
         default: return game_mode == MODE_SCORE;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input int max_cyc, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (sig(sel)) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got no response in %0d cycles, expected 1", name, max_cyc);
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1khz = 1'b1;
         @(negedge clk);
         tick_1khz = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input int cycles);
      mon_en         = 1'b0;
      start          = 1'b0;
      countdown_done = 1'b0;
      delay_done     = 1'b0;
      tick_1khz      = 1'b0;
      set_hits(2'b00);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      chk("rst_countdown_start", 32'(countdown_start), 32'd0);
      chk("rst_delay_start", 32'(delay_start), 32'd0);
      chk("rst_stopwatch_clear", 32'(stopwatch_clear), 32'd0);
      chk("rst_stopwatch_run", 32'(stopwatch_run), 32'd0);
      chk("rst_game_mode", 32'(game_mode), 32'(MODE_SCORE));
      chk("rst_winner", 32'(winner), 32'(WIN_NONE));
      chk("rst_jump_start", 32'(jump_start), 32'd0);
      chk("rst_p1_wins", 32'(p1_wins), 32'd0);
      chk("rst_p2_wins", 32'(p2_wins), 32'd0);
      chk("rst_match_over", 32'(match_over), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst  = 1'b0;
      m_p1 = 0;
      m_p2 = 0;
      m_mo = 1'b0;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
   endtask

   // One complete round; hits bit0 = P1, bit1 = P2.
   task automatic run_round(input int kind, input logic [1:0] hits, input int react_ticks);
      logic [RW-1:0] e;
      int            s1, s2;
      if (m_mo) begin
         m_p1 = 0;
         m_p2 = 0;
         m_mo = 1'b0;
      end
      s1 = m_p1;
      s2 = m_p2;
      predict(kind, hits, e);
      exp_q.push_back(e);

      start = 1'b1;
      wait_sig(0, 10, "countdown_start_pulse");
      chk("stopwatch_clear_pulse", 32'(stopwatch_clear), 32'd1);
      chk("mode_countdown", 32'(game_mode), 32'(MODE_COUNTDOWN));
      chk("winner_cleared", 32'(winner), 32'(WIN_NONE));
      chk("jump_cleared", 32'(jump_start), 32'd0);
      chk("p1_wins_at_start", 32'(p1_wins), 32'(s1));
      chk("p2_wins_at_start", 32'(p2_wins), 32'(s2));
      chk("match_over_at_start", 32'(match_over), 32'd0);
      start = 1'b0;
      @(negedge clk);
      chk("countdown_start_width", 32'(countdown_start), 32'd0);

      if (kind == K_JUMP_CD) begin
         set_hits(hits);
         wait_sig(3, 10, "jump_cd_end");
      end else begin
         countdown_done = 1'b1;
         wait_sig(1, 10, "delay_start_pulse");
         countdown_done = 1'b0;
         chk("mode_delay", 32'(game_mode), 32'(MODE_STOPWATCH));
         chk("run_low_in_delay", 32'(stopwatch_run), 32'd0);
         @(negedge clk);
         chk("delay_start_width", 32'(delay_start), 32'd0);
         if (kind == K_JUMP_DL) begin
            set_hits(hits);
            wait_sig(3, 10, "jump_dl_end");
            delay_done = 1'b1;
            repeat (3) @(negedge clk);
            delay_done = 1'b0;
            chk("run_after_late_delay_done", 32'(stopwatch_run), 32'd0);
            chk("mode_after_late_delay_done", 32'(game_mode), 32'(MODE_SCORE));
         end else begin
            delay_done = 1'b1;
            wait_sig(2, 10, "react_entry");
            delay_done = 1'b0;
            chk("mode_react", 32'(game_mode), 32'(MODE_STOPWATCH));
            if (kind == K_TIMEOUT) begin
               tick_n(TMO - 1);
               chk("run_before_timeout", 32'(stopwatch_run), 32'd1);
               tick_n(1);
               wait_sig(3, 10, "timeout_end");
            end else if (kind == K_LAST_TICK) begin
               tick_n(TMO - 1);
               chk("run_before_last_tick", 32'(stopwatch_run), 32'd1);
               tick_1khz = 1'b1;
               set_hits(hits);
               @(negedge clk);
               tick_1khz = 1'b0;
               wait_sig(3, 10, "last_tick_end");
            end else begin
               // A start press mid-reaction must be ignored.
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
               tick_n(react_ticks);
               chk("run_during_react", 32'(stopwatch_run), 32'd1);
               set_hits(hits);
               wait_sig(3, 10, "react_end");
            end
         end
      end
      set_hits(2'b00);
      repeat (3) @(negedge clk);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [RW-1:0] e;
      if (mon_en) begin
         if (stopwatch_run)
            chk("run_only_in_stopwatch_mode", 32'(game_mode), 32'(MODE_STOPWATCH));
         if (game_mode == MODE_SCORE && prev_mode != MODE_SCORE) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_round_end: got round end, expected none");
            end else begin
               e = exp_q.pop_front();
               chk("round_result", 32'({winner, jump_start, p1_wins, p2_wins, match_over}), 32'(e));
               chk("run_low_at_end", 32'(stopwatch_run), 32'd0);
            end
         end
      end
      prev_mode = game_mode;
   end

   // ---------------- stimulus ----------------
   initial begin
      int         kind;
      logic [1:0] h;

      do_reset(3);

      run_round(K_REACT, 2'b01, 250);    // P1 reacts after 250 ticks
      run_round(K_JUMP_DL, 2'b10, 0);    // P2 jumps in DELAY -> P1 credited
      run_round(K_REACT, 2'b11, 40);     // tie in REACT
      run_round(K_JUMP_CD, 2'b11, 0);    // tie jump in COUNTDOWN
      run_round(K_TIMEOUT, 2'b00, 0);    // void round
      run_round(K_LAST_TICK, 2'b10, 0);  // P2 hit on the final tick wins
      run_round(K_REACT, 2'b10, 17);     // P2 second win
      run_round(K_JUMP_CD, 2'b01, 0);    // P1 jumps -> P2 third win, match over
      chk("match_over_flag", 32'(match_over), 32'd1);
      chk("p2_final_wins", 32'(p2_wins), 32'd3);

      for (int r = 0; r < 20; r++) begin
         kind = int'($urandom_range(0, 2));
         h    = 2'($urandom_range(1, 3));
         run_round(kind, h, int'($urandom_range(1, 300)));
      end

      // Reset in the middle of REACT: no result expected for this round.
      start = 1'b1;
      wait_sig(0, 10, "mid_reset_countdown_start");
      start = 1'b0;
      countdown_done = 1'b1;
      wait_sig(1, 10, "mid_reset_delay_start");
      countdown_done = 1'b0;
      delay_done = 1'b1;
      wait_sig(2, 10, "mid_reset_react_entry");
      delay_done = 1'b0;
      tick_n(5);
      do_reset(1);

      // P1 switch held through reset must never count as a hit.
      hold_p1 = 1'b1;
      do_reset(2);
      run_round(K_REACT, 2'b10, 30);
      hold_p1 = 1'b0;
      set_hits(2'b00);
      repeat (5) @(negedge clk);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit.
   initial begin
      #900000;
      bad++;
      $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
